fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the PC and drives the word address into imem; imem returns rdata combinationally in the same cycle.
- Registers {pc, instruction, valid} into the IF/ID pipeline register.
- Handles decode-requested stalls, branch/jump redirects, and halt on a terminating instruction.

Parameters:
- DATA_WIDTH, 32, instruction/PC width
- BUS_WIDTH, 10, imem word-address width (imem depth 2^BUS_WIDTH words)
- RESET_PC, 32'h0000_0000, PC value after reset
- HALT_INSTR, 32'h0000_000C, encoding that stops fetch (MIPS syscall)

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and IF/ID register
- redirect_valid  in  1  load a new PC (branch/jump taken)
- redirect_pc  in  DATA_WIDTH  redirect target byte address
- imem_addr  out  BUS_WIDTH  word address to imem = pc[BUS_WIDTH+1:2] (combinational)
- imem_rdata  in  DATA_WIDTH  instruction from imem, same cycle
- if_pc  out  DATA_WIDTH  PC of the registered instruction
- if_instr  out  DATA_WIDTH  registered instruction
- if_valid  out  1  if_instr is a real instruction, not a bubble
- halted  out  1  fetch has stopped on HALT_INSTR

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, if_pc=0, if_instr=0 (nop), if_valid=0, halted=0, FSM=RUN.
  - Reset asserted mid-operation discards the in-flight instruction immediately.
- FSM states:
  - RUN: fetch active.
  - HALT: fetch stopped. Left only via reset.
- RUN, per cycle, priority redirect > stall > fetch:
  - redirect_valid=1:
    - pc <= {redirect_pc[31:2],2'b00}; misaligned targets are silently aligned.
    - if_valid <= 0, if_instr <= 0, if_pc <= 0.
    - Redirect beats a simultaneous stall.
  - stall=1 (no redirect): pc, if_pc, if_instr, if_valid all hold.
  - Otherwise (fetch):
    - if_pc <= pc, if_instr <= imem_rdata, if_valid <= 1.
    - pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Fetch with imem_rdata==HALT_INSTR:
    - The instruction is still registered with if_valid=1.
    - pc holds, FSM -> HALT.
    - halted=1 from the following cycle.
- HALT:
  - halted=1, pc holds, redirect_valid ignored.
  - stall=1: IF/ID holds.
  - stall=0: if_valid <= 0, if_instr <= 0.
- Latency: instruction at PC p appears on if_instr one cycle after imem_addr = p[BUS_WIDTH+1:2].
- Address range:
  - imem_addr is pc truncated, so PCs at or beyond 2^(BUS_WIDTH+2) alias into imem.
  - pc itself keeps full width.
- No outputs other than imem_addr are combinational.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt +1 per RUN-state fetch, including the HALT_INSTR fetch.
  - stall_cnt +1 per RUN cycle with stall=1 and redirect_valid=0.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Deassert rst_n; imem holds 0x20080001 @0, 0x20090002 @4.
   -> cycle 0: imem_addr=0.
   -> cycle 1: if_pc=0, if_instr=0x20080001, if_valid=1, imem_addr=1.
   -> cycle 2: if_pc=4, if_instr=0x20090002.
2. Assert stall for 3 cycles with pc=8.
   -> imem_addr stays 2; if_pc=4 and if_instr hold all 3 cycles.
   -> fetch resumes at 8 on the first unstalled cycle.
3. redirect_valid=1 with redirect_pc=0x2E and stall=1 in the same cycle.
   -> next cycle: imem_addr=0x0B, if_valid=0.
   -> following cycle: if_pc=0x2C, if_valid=1.
4. Word @0x40 = 0x0000000C, reached by sequential fetch.
   -> if_pc=0x40, if_valid=1.
   -> next cycle: halted=1, imem_addr stuck at 0x10.
   -> then if_valid=0.
   -> a later redirect to 0x0 is ignored.
5. Pulse rst_n low between clock edges while running at pc=0x24.
   -> if_valid=0, halted=0, imem_addr=0 immediately, before the next clk edge.
6. With FETCH_PERF_CNT_EN defined, run 5 fetches, 2 stall cycles and 1 redirect.
   -> fetch_cnt=5, stall_cnt=2.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses imem and fills the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the saturating fetch/stall performance counters.
module fetch_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           BUS_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000),
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = DATA_WIDTH'(32'h0000_000C)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [BUS_WIDTH-1:0]  imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  if_valid,
  output logic                  halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
  logic                  if_valid_q, if_valid_d;
  logic                  halted_q, halted_d;

  // Next-state: redirect beats stall beats fetch while running; HALT only drains IF/ID.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc & ALIGN_MASK;
          if_pc_d    = '0;
          if_instr_d = '0;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_pc_d    = pc_q;
          if_instr_d = imem_rdata;
          if_valid_d = 1'b1;
          if (imem_rdata == HALT_INSTR) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      ST_HALT: begin
        if (!stall) begin
          if_instr_d = '0;
          if_valid_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr = pc_q[BUS_WIDTH+1:2];
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;
  assign halted    = halted_q;

`ifdef FETCH_PERF_CNT_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             fetch_c, stall_c;

  assign fetch_c = (state_q == ST_RUN) && !redirect_valid && !stall;
  assign stall_c = (state_q == ST_RUN) && !redirect_valid && stall;

  // Saturating event counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_c && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle-level reference model plus literal spot checks.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'h0000_000C;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  logic [31:0] mem [1024];

  int n_pass  = 0;
  int n_total = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  assign imem_rdata = mem[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: what the IF/ID register must hold after each edge.
  logic [31:0] m_pc, m_if_pc, m_if_instr, m_fcnt, m_scnt;
  logic        m_valid, m_halted;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_if_pc <= 32'h0; m_if_instr <= 32'h0;
      m_valid <= 1'b0; m_halted <= 1'b0; m_fcnt <= 32'h0; m_scnt <= 32'h0;
    end else if (m_halted) begin
      if (!stall) begin
        m_valid    <= 1'b0;
        m_if_instr <= 32'h0;
      end
    end else if (redirect_valid) begin
      m_pc       <= {redirect_pc[31:2], 2'b00};
      m_if_pc    <= 32'h0;
      m_if_instr <= 32'h0;
      m_valid    <= 1'b0;
    end else if (stall) begin
      if (m_scnt != 32'hFFFF_FFFF) m_scnt <= m_scnt + 32'd1;
    end else begin
      m_if_pc    <= m_pc;
      m_if_instr <= mem[m_pc[11:2]];
      m_valid    <= 1'b1;
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt <= m_fcnt + 32'd1;
      if (mem[m_pc[11:2]] == HALT) m_halted <= 1'b1;
      else m_pc <= m_pc + 32'd4;
    end
  end

  // Compare every cycle, mid-way between edges.
  always @(negedge clk) begin
    check("cmp_imem_addr", 32'(imem_addr), 32'(m_pc[11:2]));
    check("cmp_if_pc",     if_pc,          m_if_pc);
    check("cmp_if_instr",  if_instr,       m_if_instr);
    check("cmp_if_valid",  32'(if_valid),  32'(m_valid));
    check("cmp_halted",    32'(halted),    32'(m_halted));
`ifdef FETCH_PERF_CNT_EN
    check("cmp_fetch_cnt", fetch_cnt, m_fcnt);
    check("cmp_stall_cnt", stall_cnt, m_scnt);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[0]  = 32'h2008_0001;
    mem[1]  = 32'h2009_0002;
    mem[16] = HALT;

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    cyc(2);
    check("rst_addr",   32'(imem_addr), 32'h0);
    check("rst_if_pc",  if_pc,          32'h0);
    check("rst_instr",  if_instr,       32'h0);
    check("rst_valid",  32'(if_valid),  32'h0);
    check("rst_halted", 32'(halted),    32'h0);

    // Sequential fetch after reset
    rst_n = 1'b1;
    check("t1_c0_addr", 32'(imem_addr), 32'h0);
    cyc(1);
    check("t1_c1_pc",    if_pc,          32'h0);
    check("t1_c1_instr", if_instr,       32'h2008_0001);
    check("t1_c1_valid", 32'(if_valid),  32'h1);
    check("t1_c1_addr",  32'(imem_addr), 32'h1);
    cyc(1);
    check("t1_c2_pc",    if_pc,          32'h4);
    check("t1_c2_instr", if_instr,       32'h2009_0002);

    // Three stalled cycles at pc=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t2_stall_addr",  32'(imem_addr), 32'h2);
      check("t2_stall_pc",    if_pc,          32'h4);
      check("t2_stall_instr", if_instr,       32'h2009_0002);
    end
    stall = 1'b0;
    cyc(1);
    check("t2_resume_pc",    if_pc,          32'h8);
    check("t2_resume_instr", if_instr,       32'h2000_0002);
    check("t2_resume_addr",  32'(imem_addr), 32'h3);

    // Misaligned redirect together with stall
    redirect_valid = 1'b1; redirect_pc = 32'h2E; stall = 1'b1;
    cyc(1);
    redirect_valid = 1'b0; stall = 1'b0;
    check("t3_addr",  32'(imem_addr), 32'h0B);
    check("t3_valid", 32'(if_valid),  32'h0);
    cyc(1);
    check("t3_pc",    if_pc,          32'h2C);
    check("t3_valid2", 32'(if_valid), 32'h1);
    check("t3_instr", if_instr,       32'h2000_000B);

    // Run into the halt word at 0x40
    cyc(4);
    check("t4_pre_pc", if_pc, 32'h3C);
    cyc(1);
    check("t4_pc",     if_pc,          32'h40);
    check("t4_instr",  if_instr,       HALT);
    check("t4_valid",  32'(if_valid),  32'h1);
    check("t4_halted", 32'(halted),    32'h1);
    check("t4_addr",   32'(imem_addr), 32'h10);
    stall = 1'b1;
    cyc(1);
    stall = 1'b0;
    check("t4_hold_valid", 32'(if_valid),  32'h1);
    check("t4_hold_addr",  32'(imem_addr), 32'h10);
    cyc(1);
    check("t4_drain_valid", 32'(if_valid), 32'h0);
    check("t4_drain_instr", if_instr,      32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    cyc(1);
    redirect_valid = 1'b0;
    check("t4_redir_ign_addr", 32'(imem_addr), 32'h10);
    check("t4_redir_ign_halt", 32'(halted),    32'h1);

    // Asynchronous reset pulses: from HALT, then mid-run at pc=0x24
    rst_n = 1'b0;
    #1;
    check("t5a_halted", 32'(halted),    32'h0);
    check("t5a_addr",   32'(imem_addr), 32'h0);
    #1 rst_n = 1'b1;
    cyc(9);
    check("t5_pre_addr", 32'(imem_addr), 32'h9);
    rst_n = 1'b0;
    #1;
    check("t5_valid",  32'(if_valid),  32'h0);
    check("t5_halted", 32'(halted),    32'h0);
    check("t5_addr",   32'(imem_addr), 32'h0);
    #1 rst_n = 1'b1;

    // 5 fetches, 2 stalls, 1 redirect
    cyc(3);
    stall = 1'b1;
    cyc(2);
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(2);
    check("t6_pc",    if_pc,          32'h104);
    check("t6_instr", if_instr,       32'h2000_0041);
    check("t6_addr",  32'(imem_addr), 32'h42);
`ifdef FETCH_PERF_CNT_EN
    check("t6_fetch_cnt", fetch_cnt, 32'd5);
    check("t6_stall_cnt", stall_cnt, 32'd2);
`endif

    // PC wrap at the top of the address space with aliasing into imem
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cyc(1);
    redirect_valid = 1'b0;
    check("wrap_addr_hi", 32'(imem_addr), 32'h3FF);
    cyc(1);
    check("wrap_pc",    if_pc,          32'hFFFF_FFFC);
    check("wrap_instr", if_instr,       32'h2000_03FF);
    check("wrap_addr0", 32'(imem_addr), 32'h0);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
